accum_fwd: RTL and testbench
============================

ACCUM_FWD -- requirements
Module: accum_fwd

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, with ports named clk and rst as elsewhere in the codebase.
REQ-002 Parameter DATAW SHALL default to 32 and give the width of one lane.
REQ-003 Parameter LANES SHALL default to 4 and give the number of parallel lanes.
REQ-004 Parameter DEPTH SHALL default to 512 and give the number of accumulator entries.
REQ-005 Parameter ADDRW SHALL default to $clog2(DEPTH) and give the address width.
REQ-006 Parameter SAT SHALL default to 0; 0 selects wrap-around addition and 1 selects signed saturation.
REQ-007 Parameter OUT_DEPTH SHALL default to 8 and give the number of result-queue entries; the minimum is 4.
REQ-008 The port list SHALL be, clock and reset first:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  input operation valid.
- o_ready  out  1  block can accept an input operation.
- i_data  in  LANES*DATAW  lane data; lane k is at bits [k*DATAW +: DATAW].
- i_addr  in  ADDRW  accumulator entry.
- i_accum  in  1  1 = add to the stored entry; 0 = overwrite the entry.
- i_last  in  1  emit the resulting value.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_result  out  LANES*DATAW  result data.
- o_addr  out  ADDRW  entry the result came from.
- o_sat  out  1  sticky flag: some lane saturated.

Function
REQ-009 An operation SHALL be accepted in any cycle where i_valid and o_ready are both 1; a cycle where i_valid=1 and o_ready=0 SHALL be ignored and SHALL leave no side effects.
REQ-010 The pipeline SHALL run in four stages: S0 accepts the operation and issues the memory read of i_addr; S1 receives the read data, selects the operand and computes the lanes; S2 writes the result back (wen=1); S3 holds the value committed in the previous cycle.
REQ-011 The memory read latency SHALL be 1 cycle; a read and a write to the same address in the same cycle SHALL return the old data.
REQ-012 In S1 the operand SHALL be chosen in this priority order: the S2 value if S2 is valid and addresses match; otherwise the S3 value if S3 is valid and addresses match; otherwise the memory read data.
REQ-013 Back-to-back operations to the same address SHALL therefore accumulate with no stall and no lost update.
REQ-014 In S1, when i_accum=1, each lane SHALL compute operand plus data.
REQ-015 In S1, when i_accum=0, each lane SHALL take the data value; the stored value is ignored.
REQ-016 With SAT=0, each lane sum SHALL be taken modulo 2^DATAW.
REQ-017 With SAT=1, each lane SHALL be treated as signed and clamped to the range -2^(DATAW-1) to 2^(DATAW-1)-1; any clamp SHALL set o_sat, which stays set until reset.
REQ-018 Every accepted operation SHALL write its result to its entry, including operations with i_last=1.
REQ-019 Operations with i_last=1 SHALL push {result, address} into the result queue in S2.
REQ-020 With the queue empty and i_ready=1, o_valid SHALL rise exactly 3 cycles after acceptance.
REQ-021 The output side SHALL follow valid/ready: o_result and o_addr SHALL hold stable while o_valid=1 and i_ready=0, and a result SHALL pop when o_valid and i_ready are both 1.
REQ-022 o_ready SHALL be 1 exactly when the queue has at least 3 free entries, counting results in flight in S1 and S2, so the queue never overflows.
REQ-023 When the queue is full, a push and a pop in the same cycle SHALL both take effect.
REQ-024 Results SHALL leave in acceptance order.
REQ-025 The first operation to any entry after reset SHALL use i_accum=0; an i_accum=1 operation to an unwritten entry gives an undefined result, and the bench SHALL not check it.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL clear o_valid, o_sat and all stage valid bits to 0, and empty the result queue.
REQ-027 When rst=1 at a clock edge, o_result and o_addr SHALL be 0, and o_ready SHALL be 0 during reset and 1 in the first cycle after it.
REQ-028 Reset in the middle of an operation SHALL discard every in-flight operation; no write SHALL occur in the cycle after reset.
REQ-029 Memory contents SHALL not be reset.

Structure
REQ-030 A shared package SHALL hold the stage record typedef (valid, addr, accum, last, data) and the localparams for the forwarding-hazard depth (2) and the in-flight reserve (3).
REQ-031 Storage SHALL reuse the existing memory_block, with DATAW=LANES*DATAW and DEPTH=DEPTH.
REQ-032 The result queue SHALL be one natural sub-module: an instance of the existing fifo, with DATAW=LANES*DATAW+ADDRW and DEPTH=OUT_DEPTH.

Verification
REQ-033 Basic accumulate, with DATAW=32 and LANES=4, i_ready=1: send addr 5 with i_accum=0, data {1,2,3,4}; then addr 5 with i_accum=1, data {10,20,30,40}, i_last=1, on consecutive cycles -> o_result={11,22,33,44} and o_addr=5, 3 cycles after the second acceptance.
REQ-034 Forwarding depth 2: three operations to addr 7 in cycles t, t+1, t+2, with i_accum=0,1,1, data 1,2,3 in every lane and i_last only on the third -> every lane of the result = 6.
REQ-035 Wrap-around and saturation: with SAT=0, 0xFFFFFFFF+2 -> 0x00000001 and o_sat=0; with SAT=1, 0x7FFFFFF0+0x20 -> 0x7FFFFFFF and o_sat=1, and o_sat stays 1 after later normal operations.
REQ-036 Back-pressure, with OUT_DEPTH=8: hold i_ready=0 and stream i_last operations to addrs 0..9 -> o_ready falls after 6 acceptances; release i_ready -> results appear in order 0..9 and none are lost.
REQ-037 Reset mid-stream: accept 2 operations, assert rst in the next cycle -> o_valid=0, no memory write in the cycle after reset, o_ready=1 in the first cycle after reset.

Source files
------------

// File: rtl/accum_fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_fwd_pkg
// Description : Shared types and constants for the forwarding accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package accum_fwd_pkg;

  // Widest lane vector and address a stage record can carry; instances use
  // the low bits and the rest stay zero.
  localparam int STAGE_DATA_MAXW = 1024;
  localparam int STAGE_ADDR_MAXW = 32;

  // Number of younger pipeline stages that can hold an uncommitted value
  // for the entry being read in S1 (S2 and S3).
  localparam int FWD_DEPTH = 2;

  // Result-queue slots kept free so operations already accepted can land.
  localparam int INFLIGHT_RESERVE = 3;

  typedef struct packed {
    logic                       valid;
    logic [STAGE_ADDR_MAXW-1:0] addr;
    logic                       accum;
    logic                       last;
    logic [STAGE_DATA_MAXW-1:0] data;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// Module      : fifo
// Description : Synchronous FIFO with registered pointers and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DATAW-1:0] wdata,
  input  logic             pop,
  output logic [DATAW-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNTW-1:0]  count
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATAW-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // A full queue still takes a push when the same cycle pops.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNTW'(do_push) - CNTW'(do_pop);
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/memory_block.sv
`default_nettype none
// ============================================================================
// Module      : memory_block
// Description : Simple dual-port RAM, 1-cycle read, read-before-write.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_block #(
  parameter int DATAW = 32,
  parameter int DEPTH = 512,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [ADDRW-1:0] waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic [ADDRW-1:0] raddr,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem [DEPTH];

  // Write port and registered read; a same-address collision returns old data.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/accum_fwd.sv
`default_nettype none
// ============================================================================
// Module      : accum_fwd
// Description : Multi-lane accumulator memory with S2/S3 result forwarding
//               and a valid/ready result queue for i_last operations.
// Revision    : 1.0 - initial release
// ============================================================================
module accum_fwd
  import accum_fwd_pkg::*;
#(
  parameter int DATAW     = 32,
  parameter int LANES     = 4,
  parameter int DEPTH     = 512,
  parameter int ADDRW     = $clog2(DEPTH),
  parameter int SAT       = 0,
  parameter int OUT_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [LANES*DATAW-1:0] i_data,
  input  logic [ADDRW-1:0]       i_addr,
  input  logic                   i_accum,
  input  logic                   i_last,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES*DATAW-1:0] o_result,
  output logic [ADDRW-1:0]       o_addr,
  output logic                   o_sat
);

  localparam int VECW = LANES * DATAW;
  localparam int QW   = VECW + ADDRW;
  localparam int CNTW = $clog2(OUT_DEPTH + 1);
  localparam logic [DATAW-1:0] SMAX = {1'b0, {(DATAW-1){1'b1}}};
  localparam logic [DATAW-1:0] SMIN = {1'b1, {(DATAW-1){1'b0}}};

  if (OUT_DEPTH < 4) begin : g_chk_out_depth
    $error("accum_fwd: OUT_DEPTH must be at least 4");
  end
  if (VECW > STAGE_DATA_MAXW || ADDRW > STAGE_ADDR_MAXW) begin : g_chk_width
    $error("accum_fwd: lane vector or address wider than stage record");
  end

  stage_t           s1, s2, s3;
  stage_t           fwd [FWD_DEPTH];
  logic             accept;
  logic [VECW-1:0]  rd_data, operand, result;
  logic [LANES-1:0] clamp;
  logic             q_push, q_pop, q_full, q_empty;
  logic [QW-1:0]    q_wdata, q_rdata;
  logic [CNTW-1:0]  q_count;
  logic [31:0]      reserved;
  logic             unused_bits;

  assign accept = i_valid & o_ready;

  memory_block #(.DATAW(VECW), .DEPTH(DEPTH), .ADDRW(ADDRW)) u_mem (
    .clk   (clk),
    .wen   (s2.valid & ~rst),
    .waddr (s2.addr[ADDRW-1:0]),
    .wdata (s2.data[VECW-1:0]),
    .raddr (i_addr),
    .rdata (rd_data)
  );

  // Pipeline registers: S0 -> S1 captures the operation, S1 -> S2 the result,
  // S2 -> S3 keeps the value just committed for one more cycle of forwarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= '{valid: accept, addr: STAGE_ADDR_MAXW'(i_addr), accum: i_accum,
              last: i_last, data: STAGE_DATA_MAXW'(i_data)};
      s2 <= '{valid: s1.valid, addr: s1.addr, accum: s1.accum,
              last: s1.last, data: STAGE_DATA_MAXW'(result)};
      s3 <= s2;
    end
  end

  // Index 0 is the youngest stage and wins over older ones.
  assign fwd[0] = s2;
  assign fwd[1] = s3;

  // Operand select: youngest matching in-flight value, else memory read data.
  always_comb begin
    operand = rd_data;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (fwd[i].valid && (fwd[i].addr == s1.addr)) operand = fwd[i].data[VECW-1:0];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DATAW-1:0] opnd, din, lane_sum;
    assign opnd = operand[k*DATAW +: DATAW];
    assign din  = s1.data[k*DATAW +: DATAW];
    if (SAT != 0) begin : g_sat
      logic [DATAW:0] sum;
      logic           ovf;
      assign sum      = {opnd[DATAW-1], opnd} + {din[DATAW-1], din};
      assign ovf      = sum[DATAW] ^ sum[DATAW-1];
      assign lane_sum = ovf ? (sum[DATAW] ? SMIN : SMAX) : sum[DATAW-1:0];
      assign clamp[k] = s1.accum & ovf;
    end else begin : g_wrap
      assign lane_sum = opnd + din;
      assign clamp[k] = 1'b0;
    end
    assign result[k*DATAW +: DATAW] = s1.accum ? lane_sum : din;
  end

  // Sticky saturation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                     o_sat <= 1'b0;
    else if (s1.valid && |clamp) o_sat <= 1'b1;
  end

  assign q_push  = s2.valid & s2.last;
  assign q_wdata = {s2.data[VECW-1:0], s2.addr[ADDRW-1:0]};
  assign q_pop   = o_valid & i_ready;

  fifo #(.DATAW(QW), .DEPTH(OUT_DEPTH), .CNTW(CNTW)) u_outq (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Queue slots already claimed by results in S1/S2 plus the safety reserve.
  assign reserved = 32'(q_count) + 32'(s1.valid & s1.last) + 32'(s2.valid & s2.last)
                  + 32'(INFLIGHT_RESERVE);
  assign o_ready  = ~rst & (reserved <= 32'(OUT_DEPTH));
  assign o_valid  = ~q_empty;
  assign o_result = o_valid ? q_rdata[QW-1:ADDRW] : '0;
  assign o_addr   = o_valid ? q_rdata[ADDRW-1:0] : '0;

  assign unused_bits = ^{s1, s2, s3, q_full};

endmodule
`default_nettype wire

// File: tb/tb_accum_fwd.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_fwd
// Description : Randomized + directed bench for accum_fwd; a wrap-around and a
//               saturating instance run the same stimulus against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_fwd;

  localparam int DATAW = 32;
  localparam int LANES = 4;
  localparam int DEPTH = 512;
  localparam int ADDRW = 9;
  localparam int OUT_DEPTH = 8;
  localparam int VECW = LANES * DATAW;
  localparam int NEVER = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0, i_accum = 1'b0, i_last = 1'b0, i_ready = 1'b1;
  logic [VECW-1:0]  i_data = '0;
  logic [ADDRW-1:0] i_addr = '0;
  logic             o_ready [2];
  logic             o_valid [2];
  logic             o_sat [2];
  logic [VECW-1:0]  o_result [2];
  logic [ADDRW-1:0] o_addr [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  accum_fwd #(.DATAW(DATAW), .LANES(LANES), .DEPTH(DEPTH), .SAT(0), .OUT_DEPTH(OUT_DEPTH)) u_wrap (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready[0]), .i_data(i_data),
    .i_addr(i_addr), .i_accum(i_accum), .i_last(i_last), .o_valid(o_valid[0]),
    .i_ready(i_ready), .o_result(o_result[0]), .o_addr(o_addr[0]), .o_sat(o_sat[0]));

  accum_fwd #(.DATAW(DATAW), .LANES(LANES), .DEPTH(DEPTH), .SAT(1), .OUT_DEPTH(OUT_DEPTH)) u_sat (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready[1]), .i_data(i_data),
    .i_addr(i_addr), .i_accum(i_accum), .i_last(i_last), .o_valid(o_valid[1]),
    .i_ready(i_ready), .o_result(o_result[1]), .o_addr(o_addr[1]), .o_sat(o_sat[1]));

  // ---------------- reference model ----------------
  typedef struct {
    logic [VECW-1:0]  r0, r1;
    logic [ADDRW-1:0] addr;
    int               vis;
    bit               chk;
  } exp_t;

  typedef struct {
    int               cyc;
    logic [ADDRW-1:0] addr;
    logic [VECW-1:0]  old0, old1;
    bit               was_written;
  } hist_t;

  logic [VECW-1:0] mm0 [DEPTH];
  logic [VECW-1:0] mm1 [DEPTH];
  bit              written [DEPTH];
  exp_t            expq [$];
  hist_t           hist [$];
  int              sat_vis = NEVER;
  int              n_checks = 0;
  int              n_fail = 0;
  bit              prev_rst = 1'b1;
  bit              last_accepted;

  task automatic check(input string tag, input logic [VECW-1:0] got, input logic [VECW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] lane_fn(input bit sat, input logic [DATAW-1:0] a,
                                               input logic [DATAW-1:0] b, output bit clamped);
    longint s, hi, lo;
    hi = (longint'(1) <<< (DATAW - 1)) - 1;
    lo = -(longint'(1) <<< (DATAW - 1));
    clamped = 1'b0;
    if (sat) begin
      s = longint'($signed(a)) + longint'($signed(b));
      if (s > hi)      begin s = hi; clamped = 1'b1; end
      else if (s < lo) begin s = lo; clamped = 1'b1; end
    end else begin
      s = longint'(a) + longint'(b);
    end
    return s[DATAW-1:0];
  endfunction

  function automatic logic [VECW-1:0] vec_fn(input bit sat, input logic [VECW-1:0] old,
                                             input logic [VECW-1:0] d, input bit acc,
                                             output bit clamped);
    logic [VECW-1:0] r;
    bit c;
    clamped = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (!acc) r[k*DATAW +: DATAW] = d[k*DATAW +: DATAW];
      else begin
        r[k*DATAW +: DATAW] = lane_fn(sat, old[k*DATAW +: DATAW], d[k*DATAW +: DATAW], c);
        clamped |= c;
      end
    end
    return r;
  endfunction

  task automatic model_accept(input int c);
    logic [VECW-1:0] r0, r1;
    bit c0, c1, defined;
    hist.push_back('{cyc: c, addr: i_addr, old0: mm0[i_addr], old1: mm1[i_addr],
                     was_written: written[i_addr]});
    defined = !i_accum || written[i_addr];
    r0 = vec_fn(1'b0, mm0[i_addr], i_data, i_accum, c0);
    r1 = vec_fn(1'b1, mm1[i_addr], i_data, i_accum, c1);
    if (defined && c1 && (c + 2 < sat_vis)) sat_vis = c + 2;
    mm0[i_addr] = r0;
    mm1[i_addr] = r1;
    written[i_addr] = defined;
    if (i_last) expq.push_back('{r0: r0, r1: r1, addr: i_addr, vis: c + 3, chk: defined});
  endtask

  // Operations whose write-back would land in or after the reset cycle are lost.
  task automatic model_reset(input int c);
    hist_t h;
    while (hist.size() > 0 && hist[$].cyc >= c - 2) begin
      h = hist.pop_back();
      mm0[h.addr] = h.old0;
      mm1[h.addr] = h.old1;
      written[h.addr] = h.was_written;
    end
    expq.delete();
    sat_vis = NEVER;
  endtask

  // One clock: drive inputs at the falling edge, compare, then advance the model.
  task automatic step(input bit v, input logic [ADDRW-1:0] a, input bit acc, input bit lst,
                      input logic [VECW-1:0] d, input bit rdy, input bit r);
    bit exp_ready, exp_valid, exp_sat;
    @(negedge clk);
    i_valid = v; i_addr = a; i_accum = acc; i_last = lst; i_data = d; i_ready = rdy; rst = r;
    #1;
    exp_ready = !rst && (expq.size() + 3 <= OUT_DEPTH);
    exp_valid = (expq.size() > 0) && (expq[0].vis <= cyc);
    exp_sat   = (cyc >= sat_vis);
    for (int k = 0; k < 2; k++) begin
      check(k == 0 ? "wrap.o_ready" : "sat.o_ready", VECW'(o_ready[k]), VECW'(exp_ready));
      check(k == 0 ? "wrap.o_valid" : "sat.o_valid", VECW'(o_valid[k]), VECW'(exp_valid));
      if (exp_valid && expq[0].chk) begin
        check(k == 0 ? "wrap.o_result" : "sat.o_result", o_result[k],
              k == 0 ? expq[0].r0 : expq[0].r1);
        check(k == 0 ? "wrap.o_addr" : "sat.o_addr", VECW'(o_addr[k]), VECW'(expq[0].addr));
      end
      if (prev_rst && !rst) begin
        check(k == 0 ? "wrap.rst_result" : "sat.rst_result", o_result[k], '0);
        check(k == 0 ? "wrap.rst_addr" : "sat.rst_addr", VECW'(o_addr[k]), '0);
      end
    end
    check("wrap.o_sat", VECW'(o_sat[0]), '0);
    check("sat.o_sat", VECW'(o_sat[1]), VECW'(exp_sat));
    last_accepted = i_valid && o_ready[0];
    if (rst) model_reset(cyc);
    else begin
      if (exp_valid && i_ready) void'(expq.pop_front());
      if (last_accepted) model_accept(cyc);
    end
    while (hist.size() > 0 && hist[0].cyc < cyc - 3) void'(hist.pop_front());
    prev_rst = rst;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, '0, 1'b0, 1'b0, '0, rdy, 1'b0);
  endtask

  function automatic logic [VECW-1:0] vec4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [VECW-1:0] splat(input logic [31:0] x);
    return {LANES{x}};
  endfunction

  function automatic logic [31:0] rand_lane();
    case ($urandom % 4)
      0:       return $urandom;
      1:       return 32'h7fff_ff00 | ($urandom % 256);
      2:       return 32'h8000_0000 | ($urandom % 256);
      default: return $urandom % 16;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, nacc;
    logic [ADDRW-1:0] ra;
    bit racc;
    logic [VECW-1:0] rd;

    // reset and first cycle after it
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // basic accumulate on entry 5
    step(1'b1, 9'd5, 1'b0, 1'b0, vec4(1, 2, 3, 4), 1'b1, 1'b0);
    step(1'b1, 9'd5, 1'b1, 1'b1, vec4(10, 20, 30, 40), 1'b1, 1'b0);
    idle(6, 1'b1);

    // three back-to-back operations to entry 7 exercise both forwarding stages
    step(1'b1, 9'd7, 1'b0, 1'b0, splat(1), 1'b1, 1'b0);
    step(1'b1, 9'd7, 1'b1, 1'b0, splat(2), 1'b1, 1'b0);
    step(1'b1, 9'd7, 1'b1, 1'b1, splat(3), 1'b1, 1'b0);
    idle(6, 1'b1);

    // wrap-around vs saturation, then a normal operation
    step(1'b1, 9'd9, 1'b0, 1'b0, splat(32'hffff_ffff), 1'b1, 1'b0);
    step(1'b1, 9'd9, 1'b1, 1'b1, splat(2), 1'b1, 1'b0);
    step(1'b1, 9'd10, 1'b0, 1'b0, splat(32'h7fff_fff0), 1'b1, 1'b0);
    step(1'b1, 9'd10, 1'b1, 1'b1, splat(32'h20), 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 9'd11, 1'b0, 1'b0, splat(5), 1'b1, 1'b0);
    step(1'b1, 9'd11, 1'b1, 1'b1, splat(6), 1'b1, 1'b0);
    idle(6, 1'b1);

    // back-pressure: stream ten results while downstream is stalled
    sent = 0; nacc = 0;
    for (int c = 0; c < 14; c++) begin
      step(1'b1, ADDRW'(sent), 1'b0, 1'b1, splat(32'(100 + sent)), 1'b0, 1'b0);
      if (last_accepted) begin sent++; nacc++; end
    end
    check("bp_accepts", VECW'(nacc), VECW'(6));
    for (int c = 0; c < 40 && sent < 10; c++) begin
      step(1'b1, ADDRW'(sent), 1'b0, 1'b1, splat(32'(100 + sent)), 1'b1, 1'b0);
      if (last_accepted) sent++;
    end
    check("bp_sent", VECW'(sent), VECW'(10));
    idle(10, 1'b1);
    check("bp_drained", VECW'(expq.size()), '0);

    // reset mid-stream: two overwrites are discarded, prior contents survive
    step(1'b1, 9'd20, 1'b0, 1'b0, vec4(7, 8, 9, 10), 1'b1, 1'b0);
    step(1'b1, 9'd21, 1'b0, 1'b0, vec4(11, 12, 13, 14), 1'b1, 1'b0);
    idle(4, 1'b1);
    step(1'b1, 9'd20, 1'b0, 1'b0, splat(32'hdead_0000), 1'b1, 1'b0);
    step(1'b1, 9'd21, 1'b0, 1'b0, splat(32'hdead_1111), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(1, 1'b1);
    step(1'b1, 9'd20, 1'b1, 1'b1, '0, 1'b1, 1'b0);
    step(1'b1, 9'd21, 1'b1, 1'b1, '0, 1'b1, 1'b0);
    idle(6, 1'b1);

    // randomized traffic on a small address window with occasional resets
    for (int c = 0; c < 2000; c++) begin
      ra   = ADDRW'(32 + $urandom_range(0, 7));
      racc = written[ra] ? ($urandom % 4 != 0) : 1'b0;
      rd   = vec4(rand_lane(), rand_lane(), rand_lane(), rand_lane());
      step($urandom % 4 != 0, ra, racc, $urandom % 2 == 1, rd, $urandom % 4 != 0,
           $urandom % 300 == 0);
    end

    for (int c = 0; c < 60 && expq.size() > 0; c++) idle(1, 1'b1);
    check("final_drain", VECW'(expq.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
